// File: rtl/onchip_ram_stream_pkg.sv
// Shared definitions for the on-chip RAM stream reader: default widths,
// controller state encoding and the RAM read latency.
package onchip_ram_stream_pkg;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/ram_rd_stream_fifo.sv
// Small synchronous FIFO holding returned RAM words plus their last flag.
// Output data reads as zero while empty so the stream bus is clean at idle.
module ram_rd_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/onchip_ram_stream_reader.sv
// Streams a contiguous (wrapping) range of on-chip RAM words out on a
// valid/ready interface, issuing reads only when the output buffer has room.
module onchip_ram_stream_reader
  import onchip_ram_stream_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last
);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_next_addr, r_last_addr;
  logic [ADDR_W:0]       r_remain;
  logic                  r_zero_done;
  logic [RAM_RD_LAT-1:0] r_rd_vld, r_rd_last;

  logic              w_accept, w_pop, w_room, w_issue, w_issue_last, w_done_drain;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [ADDR_W:0]   w_issue_left;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W:0]   w_fifo_q;
  int                w_in_flight;

  assign w_accept = start && !reset && (r_state == ST_IDLE) && !r_zero_done;
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    w_in_flight = 0;
    for (int i = 0; i < RAM_RD_LAT; i++) w_in_flight += int'(r_rd_vld[i]);
  end

  // Every read in flight already owns a buffer slot; a pop this cycle frees one.
  assign w_room = (w_in_flight + int'(w_occ) - int'(w_pop)) < BUF_DEPTH;

  // The first read goes out in the start cycle itself, straight from the inputs.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    w_issue_left = r_remain;
    if (r_state == ST_IDLE) begin
      w_issue      = w_accept && (word_count != '0);
      w_issue_addr = base_addr;
      w_issue_left = word_count;
    end else if (r_state == ST_RUN) begin
      w_issue = (r_remain != '0) && w_room;
    end
  end

  assign w_issue_last = w_issue && (w_issue_left == CNT_ONE);
  assign w_done_drain = (r_state == ST_DRAIN) && w_pop && out_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_remain    <= '0;
      r_zero_done <= 1'b0;
      r_rd_vld    <= '0;
      r_rd_last   <= '0;
    end else begin
      r_zero_done  <= w_accept && (word_count == '0);
      r_rd_vld[0]  <= w_issue;
      r_rd_last[0] <= w_issue_last;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        r_rd_vld[i]  <= r_rd_vld[i-1];
        r_rd_last[i] <= r_rd_last[i-1];
      end
      if (w_issue) begin
        r_last_addr <= w_issue_addr;
        r_next_addr <= w_issue_addr + ADDR_W'(1);
        r_remain    <= w_issue_left - CNT_ONE;
      end
      case (r_state)
        ST_IDLE:  if (w_issue) r_state <= w_issue_last ? ST_DRAIN : ST_RUN;
        ST_RUN:   if (w_issue_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_done_drain) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  ram_rd_stream_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_rd_vld[RAM_RD_LAT-1]),
    .i_data  ({r_rd_last[RAM_RD_LAT-1], ram_readdata}),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_fifo_q),
    .o_count (w_occ)
  );

  assign out_data       = w_fifo_q[DATA_W-1:0];
  assign out_last       = w_fifo_q[DATA_W];
  assign busy           = (r_state != ST_IDLE) || r_zero_done;
  assign done           = r_zero_done || w_done_drain;
  assign ram_chipselect = w_issue;
  assign ram_address    = w_issue ? w_issue_addr : r_last_addr;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;
endmodule

// File: doc/onchip_ram_stream_reader.md
ONCHIP_RAM_STREAM_READER -- requirements
Module: onchip_ram_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width of the on-chip RAM (2048 words).
REQ-002 Parameter DATA_W, default 32, RAM word and stream width.
REQ-003 Parameter BUF_DEPTH, default 2, output buffer entries; minimum 2.
REQ-004 clk  input  1  single clock, shared with the on-chip RAM.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a transfer; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-008 word_count  input  ADDR_W+1  number of words to read, 0..2048, captured on accepted start.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse when a transfer completes.
REQ-011 ram_address  output  ADDR_W  RAM word address.
REQ-012 ram_chipselect  output  1  RAM select; high only on read-issue cycles.
REQ-013 ram_write  output  1  constant 0; the block never writes.
REQ-014 ram_byteenable  output  DATA_W/8  constant all-ones.
REQ-015 ram_clken  output  1  constant 1.
REQ-016 ram_readdata  input  DATA_W  RAM read data, valid one cycle after address issue.
REQ-017 out_valid  output  1  stream data valid.
REQ-018 out_ready  input  1  downstream accept; transfer occurs when out_valid and out_ready are both high.
REQ-019 out_data  output  DATA_W  stream word.
REQ-020 out_last  output  1  high with the final word of a transfer.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, and DRAIN.
REQ-022 IDLE->RUN on start when word_count>0; IDLE->IDLE with done pulsed the next cycle when word_count=0, with no RAM access.
REQ-023 RUN: a read SHALL issue (ram_chipselect=1) in any cycle where issued_count<word_count and (in_flight + buffer occupancy) < BUF_DEPTH, the occupancy term counting a same-cycle output pop as freed.
REQ-024 Read latency SHALL be exactly 1 cycle; data returned in cycle N+1 SHALL be pushed into the buffer in that cycle, together with an out_last flag.
REQ-025 Address SHALL start at base_addr, increment by 1 per issue, and wrap from 2^ADDR_W-1 to 0.
REQ-026 RUN->DRAIN after the final read is issued; DRAIN->IDLE on the output handshake of the out_last word, with done pulsed that cycle and busy cleared the next cycle.
REQ-027 Words SHALL leave in address order with no loss or duplication under arbitrary out_ready patterns; the buffer SHALL never overflow.
REQ-028 With out_ready held high, the block SHALL sustain one word per cycle after an initial 2-cycle latency (start -> first out_valid).
REQ-029 Simultaneous buffer push and pop SHALL keep occupancy unchanged; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 start while busy SHALL be ignored, and parameters captured at start SHALL not change mid-transfer.
REQ-031 ram_address SHALL hold its last value when no read issues.

Reset
REQ-032 reset SHALL force the FSM to IDLE, clear the buffer and counters, and drive busy=0, done=0, out_valid=0, out_last=0, ram_chipselect=0, ram_address=0, out_data=0.
REQ-033 reset asserted mid-transfer SHALL abort the transfer without a done pulse; any read data returning in the following cycle SHALL be discarded.

Structure
REQ-034 Shared package onchip_ram_stream_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum type, and the RAM read-latency constant (1).
REQ-035 The output buffer SHALL be sub-module ram_rd_stream_fifo, a synchronous FIFO with depth BUF_DEPTH and width DATA_W+1 carrying the data word plus the last flag.

Verification
REQ-036 RAM model preloaded with mem[i]=i; start with base=0, count=4, out_ready=1 -> out_data 0,1,2,3 on consecutive cycles, first word 2 cycles after start, out_last on 3, one done pulse.
REQ-037 Wrap-around: base=2046, count=4 -> addresses 2046,2047,0,1, with data in that order.
REQ-038 Backpressure: count=16 with out_ready toggling 1-0-0-1 repeating -> all 16 words in order, occupancy never exceeds 2, no duplicates.
REQ-039 count=0 -> done 1 cycle after start, ram_chipselect never asserted, out_valid never asserted.
REQ-040 Reset asserted after 3 of 8 words have been accepted -> all outputs at reset values the next cycle, no done pulse, and a fresh start (base=100, count=2) delivers mem[100] and mem[101] correctly.
REQ-041 start pulsed again while busy -> ignored; the original transfer completes unchanged.
